// File: rtl/project_button_pio_irq_if.sv
// Avalon-MM slave bus bundle for the button PIO: register access plus the level interrupt.
// Reads have a fixed one-cycle latency: chipselect&read in cycle N gives readdata in cycle N+1. There is no waitrequest.
interface project_button_pio_irq_if;
  logic        chipselect;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output chipselect, address, read, write, writedata,
    input  readdata, irq
  );

  modport slave (
    input  chipselect, address, read, write, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/project_button_pio_irq.sv
// Input PIO for buttons and switches: 2-FF synchroniser, per-bit debounce, edge capture (W1C),
// IRQ mask and a level interrupt, accessed over an Avalon-MM slave with one-cycle read latency.
module project_button_pio_irq #(
  parameter int              WIDTH           = 3,
  parameter int              DEBOUNCE_CYCLES = 50000,
  parameter int              EDGE_MODE       = 0,
  parameter logic [WIDTH-1:0] RESET_MASK     = '0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  project_button_pio_irq_if.slave   bus,
  input  logic [WIDTH-1:0]          in_port
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_stable_d;
  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] r_irqmask;
  logic [31:0]      r_readdata;

  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_ecap_clr;
  logic             w_wr;
  logic             w_wr_mask;
  logic             w_wr_ecap;
  logic             w_rd;
  logic [31:0]      w_rd_mux;
  logic             w_unused_wdata;

  assign w_wr      = bus.chipselect & bus.write;
  assign w_rd      = bus.chipselect & bus.read;
  assign w_wr_mask = w_wr & (bus.address == 2'd1);
  assign w_wr_ecap = w_wr & (bus.address == 2'd2);
  assign w_ecap_clr = w_wr_ecap ? bus.writedata[WIDTH-1:0] : '0;
  assign w_unused_wdata = ^bus.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= in_port;
      r_s2 <= r_s1;
    end
  end

  // A bit accepts a new level only after s2 has disagreed with stable for DEBOUNCE_CYCLES
  // consecutive cycles; any agreeing cycle in between restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_s2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_stable[i] <= r_s2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    w_edge = '0;
    case (EDGE_MODE)
      0:       w_edge = r_stable & ~r_stable_d;
      1:       w_edge = ~r_stable & r_stable_d;
      default: w_edge = r_stable ^ r_stable_d;
    endcase
  end

  // Set has priority over a same-cycle W1C so an edge is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable_d <= '0;
      r_edgecap  <= '0;
      r_irqmask  <= RESET_MASK;
    end else begin
      r_stable_d <= r_stable;
      r_edgecap  <= (r_edgecap & ~w_ecap_clr) | w_edge;
      if (w_wr_mask) r_irqmask <= bus.writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (bus.address)
      2'd0:    w_rd_mux[WIDTH-1:0] = r_stable;
      2'd1:    w_rd_mux[WIDTH-1:0] = r_irqmask;
      2'd2:    w_rd_mux[WIDTH-1:0] = r_edgecap;
      default: w_rd_mux[WIDTH-1:0] = r_s2;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd ? w_rd_mux : 32'd0;
    end
  end

  assign bus.readdata = r_readdata;
  assign bus.irq      = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_project_button_pio_irq.sv
// Bench for the button PIO: three instances (rising, falling, any-edge capture) share pins and bus,
// each checked every cycle against a window-based debounce reference model.
module tb_project_button_pio_irq;
  localparam int D = 4;

  logic        clk;
  logic        reset_n;
  logic [2:0]  pin;
  logic        b_cs, b_rd, b_wr;
  logic [1:0]  b_addr;
  logic [31:0] b_wd;

  int n_checks;
  int n_fail;

  logic [31:0] exp_q[$];

  project_button_pio_irq_if if0();
  project_button_pio_irq_if if1();
  project_button_pio_irq_if if2();

  assign if0.chipselect = b_cs; assign if0.address = b_addr; assign if0.read = b_rd;
  assign if0.write = b_wr; assign if0.writedata = b_wd;
  assign if1.chipselect = b_cs; assign if1.address = b_addr; assign if1.read = b_rd;
  assign if1.write = b_wr; assign if1.writedata = b_wd;
  assign if2.chipselect = b_cs; assign if2.address = b_addr; assign if2.read = b_rd;
  assign if2.write = b_wr; assign if2.writedata = b_wd;

  project_button_pio_irq #(.WIDTH(3), .DEBOUNCE_CYCLES(D), .EDGE_MODE(0), .RESET_MASK(3'b000)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0), .in_port(pin));
  project_button_pio_irq #(.WIDTH(3), .DEBOUNCE_CYCLES(D), .EDGE_MODE(1), .RESET_MASK(3'b000)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1), .in_port(pin));
  project_button_pio_irq #(.WIDTH(3), .DEBOUNCE_CYCLES(D), .EDGE_MODE(2), .RESET_MASK(3'b101)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(if2), .in_port(pin));

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [2:0]  m_st [3];
  logic [2:0]  m_sd [3];
  logic [2:0]  m_ec [3];
  logic [2:0]  m_mk [3];
  logic [31:0] m_rd [3];
  logic [2:0]  m_s1, m_s2;
  logic [2:0]  s2_hist[$];

  function automatic logic [2:0] edge_of(input int m, input logic [2:0] st, input logic [2:0] sd);
    case (m)
      0:       return st & ~sd;
      1:       return ~st & sd;
      default: return st ^ sd;
    endcase
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      m_st[m] = 3'b000; m_sd[m] = 3'b000; m_ec[m] = 3'b000; m_rd[m] = 32'd0;
    end
    m_mk[0] = 3'b000; m_mk[1] = 3'b000; m_mk[2] = 3'b101;
    m_s1 = 3'b000; m_s2 = 3'b000;
    s2_hist.delete();
    for (int k = 0; k < D; k++) s2_hist.push_back(3'b000);
    exp_q.delete();
  endtask

  // A level is accepted once the last D synchronised samples all disagree with the current stable value.
  task automatic model_edge();
    logic [2:0] e, sel, clr, nst;
    bit all_diff;
    s2_hist.push_front(m_s2);
    while (s2_hist.size() > D) void'(s2_hist.pop_back());
    for (int m = 0; m < 3; m++) begin
      e = edge_of(m, m_st[m], m_sd[m]);
      case (b_addr)
        2'd0:    sel = m_st[m];
        2'd1:    sel = m_mk[m];
        2'd2:    sel = m_ec[m];
        default: sel = m_s2;
      endcase
      m_rd[m] = (b_cs && b_rd) ? {29'd0, sel} : 32'd0;
      clr = (b_cs && b_wr && b_addr == 2'd2) ? b_wd[2:0] : 3'b000;
      m_ec[m] = (m_ec[m] & ~clr) | e;
      if (b_cs && b_wr && b_addr == 2'd1) m_mk[m] = b_wd[2:0];
      m_sd[m] = m_st[m];
      nst = m_st[m];
      for (int i = 0; i < 3; i++) begin
        all_diff = 1'b1;
        for (int k = 0; k < D; k++) if (s2_hist[k][i] == m_st[m][i]) all_diff = 1'b0;
        if (all_diff) nst[i] = ~m_st[m][i];
      end
      m_st[m] = nst;
      exp_q.push_back(m_rd[m]);
      exp_q.push_back({31'd0, |(m_ec[m] & m_mk[m])});
    end
    m_s2 = m_s1;
    m_s1 = pin;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_rd(input int m);
    case (m)
      0:       return if0.readdata;
      1:       return if1.readdata;
      default: return if2.readdata;
    endcase
  endfunction

  function automatic logic dut_irq(input int m);
    case (m)
      0:       return if0.irq;
      1:       return if1.irq;
      default: return if2.irq;
    endcase
  endfunction

  task automatic check_all();
    logic [31:0] e_rd, e_irq;
    for (int m = 0; m < 3; m++) begin
      if (exp_q.size() < 2) begin
        check($sformatf("expq_empty_m%0d", m), 32'd0, 32'd1);
      end else begin
        e_rd  = exp_q.pop_front();
        e_irq = exp_q.pop_front();
        check($sformatf("rd_m%0d", m), dut_rd(m), e_rd);
        check($sformatf("irq_m%0d", m), {31'd0, dut_irq(m)}, e_irq);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic idle();
    b_cs = 1'b0; b_rd = 1'b0; b_wr = 1'b0; b_addr = 2'd0; b_wd = 32'd0;
  endtask

  task automatic set_read(input logic [1:0] a);
    b_cs = 1'b1; b_rd = 1'b1; b_wr = 1'b0; b_addr = a; b_wd = 32'd0;
  endtask

  task automatic set_write(input logic [1:0] a, input logic [31:0] d);
    b_cs = 1'b1; b_rd = 1'b0; b_wr = 1'b1; b_addr = a; b_wd = d;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
    set_read(a);
    step();
    v = if0.readdata;
    idle();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    for (int m = 0; m < 3; m++) begin
      check($sformatf("rst_rd_m%0d", m), dut_rd(m), 32'd0);
      check($sformatf("rst_irq_m%0d", m), {31'd0, dut_irq(m)}, 32'd0);
    end
    #19;
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] v;
    int j;
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    pin      = 3'b000;
    idle();
    #6;
    do_reset();

    // reset values through the bus
    read_reg(2'd0, v); check("t1_data", v, 32'd0);
    set_read(2'd1); step();
    check("t1_mask_m0", if0.readdata, 32'd0);
    check("t1_mask_m2", if2.readdata, 32'd5);
    check("t1_irq", {31'd0, if0.irq}, 32'd0);
    idle();

    // debounce latency and rising-edge capture
    pin = 3'b001;
    set_read(2'd0);
    steps(6);
    check("t2_data_early", if0.readdata, 32'd0);
    step();
    check("t2_data", if0.readdata, 32'd1);
    read_reg(2'd2, v); check("t2_ecap", v, 32'd1);
    check("t2_irq", {31'd0, if0.irq}, 32'd0);

    // 3-cycle glitch rejected, 4-cycle pulse accepted
    pin = 3'b011; steps(3); pin = 3'b001; steps(10);
    read_reg(2'd0, v); check("t3_glitch_data", v, 32'd1);
    read_reg(2'd2, v); check("t3_glitch_ecap", v, 32'd1);
    pin = 3'b011; steps(4); pin = 3'b001; steps(12);
    read_reg(2'd2, v); check("t3_pulse_ecap", v, 32'd3);

    // unmask raises irq next cycle; W1C clears it
    set_write(2'd1, 32'h2); step();
    check("t4_irq_on", {31'd0, if0.irq}, 32'd1);
    set_write(2'd2, 32'h2); step();
    check("t4_irq_off", {31'd0, if0.irq}, 32'd0);
    read_reg(2'd2, v); check("t4_ecap", v, 32'd1);

    // W1C colliding with a new rising edge: set wins
    set_write(2'd1, 32'h1); step(); idle();
    check("t5_irq_on", {31'd0, if0.irq}, 32'd1);
    pin = 3'b000; steps(12);
    check("t5_irq_fall", {31'd0, if0.irq}, 32'd1);
    pin = 3'b001; steps(6);
    set_write(2'd2, 32'h1); step(); idle();
    check("t5_irq_held", {31'd0, if0.irq}, 32'd1);
    read_reg(2'd2, v); check("t5_ecap", v, 32'd1);
    set_write(2'd2, 32'h1); step(); idle();
    check("t5_irq_clr", {31'd0, if0.irq}, 32'd0);

    // reset mid-debounce, then no spurious edge
    pin = 3'b101; steps(4);
    do_reset();
    pin = 3'b000;
    steps(10);
    read_reg(2'd2, v); check("t6_ecap", v, 32'd0);
    check("t6_irq", {31'd0, if0.irq}, 32'd0);

    // randomized traffic
    repeat (500) begin
      if ($urandom_range(0, 3) == 0) begin
        j = $urandom_range(0, 2);
        pin[j] = ~pin[j];
      end
      case ($urandom_range(0, 4))
        0, 1: idle();
        2:    set_read(2'($urandom_range(0, 3)));
        3:    set_write(2'($urandom_range(0, 3)), $urandom);
        default: begin
          set_write(2'($urandom_range(0, 3)), $urandom);
          b_rd = 1'b1;
        end
      endcase
      step();
    end
    idle();
    steps(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
